// File: rtl/constant_output_monitor.sv
// Constant-run monitor: samples o on en and issues one valid/ready report when o holds a level for WINDOW samples.
// Latency 1 clock from the WINDOW-th equal sample to stat_valid; the report is held stable until stat_ready accepts it.
// Optional transition counter enabled by defining CONST_MON_TOGGLE_CNT_EN; otherwise toggle_cnt is tied to 0.
module constant_output_monitor #(
    parameter int WINDOW = 4,
    parameter int CNT_W  = 8
) (
    input  logic             ck,
    input  logic             rn,
    input  logic             o,
    input  logic             en,
    output logic             stat_valid,
    input  logic             stat_ready,
    output logic             stat_level,
    output logic [CNT_W-1:0] stat_len,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] toggle_cnt
);

    typedef enum logic [1:0] {IDLE, TRACK, REPORT, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   WIN_W   = (CNT_W+1)'(WINDOW);
    localparam logic [CNT_W-1:0] WIN_N   = CNT_W'(WINDOW);

    state_t           state, state_n;
    logic             last, last_n;
    logic             pend_tog, pend_tog_n;
    logic             valid_n, level_n;
    logic [CNT_W-1:0] len_n, run_n, run_inc;
    logic [CNT_W:0]   run_wide;
    logic             same, toggle;

    assign same     = (o == last);
    assign toggle   = en && !same && (state != IDLE);
    assign run_wide = {1'b0, run_len} + 1'b1;
    assign run_inc  = (run_len == CNT_MAX) ? CNT_MAX : run_wide[CNT_W-1:0];

    always_comb begin
        state_n    = state;
        last_n     = last;
        run_n      = run_len;
        pend_tog_n = pend_tog;
        valid_n    = stat_valid;
        level_n    = stat_level;
        len_n      = stat_len;
        unique case (state)
            IDLE: begin
                if (en) begin
                    last_n  = o;
                    run_n   = CNT_W'(1);
                    state_n = TRACK;
                end
            end
            TRACK: begin
                if (en && same) begin
                    run_n = run_inc;
                    if (run_wide == WIN_W) begin
                        state_n = REPORT;
                        valid_n = 1'b1;
                        level_n = last;
                        len_n   = WIN_N;
                    end
                end else if (en) begin
                    last_n = o;
                    run_n  = CNT_W'(1);
                end
            end
            REPORT: begin
                // Keep following the run while the report waits; a toggle re-arms after accept.
                if (en && same) begin
                    run_n = run_inc;
                end else if (en) begin
                    last_n     = o;
                    run_n      = CNT_W'(1);
                    pend_tog_n = 1'b1;
                end
                if (stat_ready) begin
                    valid_n    = 1'b0;
                    pend_tog_n = 1'b0;
                    state_n    = (pend_tog || toggle) ? TRACK : HOLD;
                end
            end
            HOLD: begin
                if (en && same) begin
                    run_n = run_inc;
                end else if (en) begin
                    last_n  = o;
                    run_n   = CNT_W'(1);
                    state_n = TRACK;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rn) begin
            state      <= IDLE;
            last       <= 1'b0;
            pend_tog   <= 1'b0;
            run_len    <= '0;
            stat_valid <= 1'b0;
            stat_level <= 1'b0;
            stat_len   <= '0;
        end else begin
            state      <= state_n;
            last       <= last_n;
            pend_tog   <= pend_tog_n;
            run_len    <= run_n;
            stat_valid <= valid_n;
            stat_level <= level_n;
            stat_len   <= len_n;
        end
    end

`ifdef CONST_MON_TOGGLE_CNT_EN
    always_ff @(posedge ck) begin
        if (!rn) begin
            toggle_cnt <= '0;
        end else if (toggle && toggle_cnt != CNT_MAX) begin
            toggle_cnt <= toggle_cnt + 1'b1;
        end
    end
`else
    assign toggle_cnt = '0;
`endif

endmodule
